multicycle_cpu: RTL and testbench

- Parametrised successor to the single-path datapath: a multicycle RV64I-subset core driven by a fetch/decode/execute/memory/writeback state machine.
- Holds its own PC and instruction register.
- Instantiates the existing register_file and alu.
- Instruction and data memory are external, reached through valid/ready request ports, so the top level can insert wait states.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/alu.sv | 29 ++
 rtl/multicycle_cpu_imm_gen.sv | 25 ++
 rtl/register_file.sv | 28 ++
 rtl/multicycle_cpu.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 367 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV64I-subset core:
// FSM states, instruction field constants, ALU op codes, immediate formats.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD: return IMM_I;
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      default:         return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for the core: add, sub, and, or, xor, signed set-less-than.
module alu
  import cpu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [2:0]          op,
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  output logic [WORDSIZE-1:0] result,
  output logic                zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WORDSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/J immediate of an instruction
// word to WORDSIZE bits. Purely combinational.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:7]         insn,
  input  imm_fmt_t            fmt,
  output logic [WORDSIZE-1:0] imm
);

  always_comb begin
    // NOTE: default assignment first so no path leaves imm unassigned (no latch).
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(WORDSIZE-12){insn[31]}}, insn[31:20]};
      IMM_S: imm = {{(WORDSIZE-12){insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B: imm = {{(WORDSIZE-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_J: imm = {{(WORDSIZE-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// 32-entry integer register file, two asynchronous read ports and one
// synchronous write port; x0 reads as zero and ignores writes.
module register_file #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [WORDSIZE-1:0] wdata,
  input  logic [4:0]          raddr1,
  input  logic [4:0]          raddr2,
  output logic [WORDSIZE-1:0] rdata1,
  output logic [WORDSIZE-1:0] rdata2
);

  logic [WORDSIZE-1:0] regs [32];

  // NOTE: storage array has no reset; software initialises registers, and a
  // reset here would turn the array into flops instead of a RAM-like structure.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all clocked state.
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV64I-subset core with valid/ready instruction and data ports.
// Define PERF_COUNTERS_EN to add the perf_cycles/perf_instret counters.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                  WORDSIZE = 64,
  parameter int                  SIZE     = 512,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORDSIZE-1:0] dmem_addr,
  output logic [WORDSIZE-1:0] dmem_wdata,
  input  logic                dmem_ready,
  input  logic [WORDSIZE-1:0] dmem_rdata,
  output logic                halted,
  output logic                trap
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0]         perf_cycles,
  output logic [63:0]         perf_instret
`endif
);

  localparam logic [WORDSIZE-1:0] FOUR      = WORDSIZE'(4);
  localparam logic [WORDSIZE-1:0] LAST_WORD = WORDSIZE'(SIZE - 8);

  state_t              state;
  logic [WORDSIZE-1:0] pc, rs1_q, rs2_q, imm_q, res_q;
  logic [31:0]         ir;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [WORDSIZE-1:0] imm, rf_rdata1, rf_rdata2, rf_wdata, alu_b, alu_res, pc_plus4;
  logic [2:0]          alu_op;
  logic                alu_zero, rf_we, legal, is_sys, taken, addr_ok;

  imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
    .insn (ir[31:7]),
    .fmt  (imm_fmt_of(opcode)),
    .imm  (imm)
  );

  register_file #(.WORDSIZE(WORDSIZE)) u_register_file (
    .clk    (clk),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .op     (alu_op),
    .a      (rs1_q),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_REG:    legal = (f7 == F7_BASE && f3 inside {F3_ADD_SUB, F3_SLT, F3_XOR, F3_OR, F3_AND})
                      || (f7 == F7_SUB && f3 == F3_ADD_SUB);
      OP_IMM:    legal = (f3 == F3_ADD_SUB);
      OP_LOAD,
      OP_STORE:  legal = (f3 == F3_DWORD);
      OP_BRANCH: legal = (f3 inside {F3_BEQ, F3_BNE});
      OP_JAL:    legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  assign is_sys = (ir == INSN_ECALL) || (ir == INSN_EBREAK);

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_q;
    if (opcode == OP_REG) begin
      alu_b = rs2_q;
      case (f3)
        F3_SLT:  alu_op = ALU_SLT;
        F3_XOR:  alu_op = ALU_XOR;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = f7[5] ? ALU_SUB : ALU_ADD;
      endcase
    end else if (opcode == OP_BRANCH) begin
      alu_b  = rs2_q;
      alu_op = ALU_SUB;
    end
  end

  assign taken    = (f3 == F3_BEQ) ? alu_zero : !alu_zero;
  assign pc_plus4 = pc + FOUR;
  // The whole doubleword must fit below SIZE; 64-bit accesses must also be aligned.
  assign addr_ok  = (alu_res <= LAST_WORD) && ((WORDSIZE != 64) || (alu_res[2:0] == 3'b000));

  // JAL links in EXECUTE; everything else writes back from res_q in WB.
  assign rf_we    = (state == S_WB) || (state == S_EXECUTE && opcode == OP_JAL);
  assign rf_wdata = (state == S_WB) ? res_q : pc_plus4;

  assign imem_addr = imem_req ? pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      trap       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          rs1_q <= rf_rdata1;
          rs2_q <= rf_rdata2;
          imm_q <= imm;
          if (is_sys) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!legal) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (opcode)
            OP_BRANCH: begin
              pc       <= pc + (taken ? imm_q : FOUR);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_JAL: begin
              pc       <= pc + imm_q;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_LOAD, OP_STORE: begin
              // Range check is done on the way into MEM so a bad access never raises dmem_req.
              if (addr_ok) begin
                dmem_req   <= 1'b1;
                dmem_we    <= (opcode == OP_STORE);
                dmem_addr  <= alu_res;
                dmem_wdata <= rs2_q;
                state      <= S_MEM;
              end else begin
                trap  <= 1'b1;
                state <= S_TRAP;
              end
            end
            default: begin
              res_q <= alu_res;
              state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              pc       <= pc_plus4;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              res_q <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc       <= pc_plus4;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic retire;
  assign retire = (state == S_WB)
               || (state == S_MEM && dmem_ready && dmem_we)
               || (state == S_EXECUTE && (opcode == OP_BRANCH || opcode == OP_JAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else begin
      if (state != S_HALT && state != S_TRAP) perf_cycles <= perf_cycles + 64'd1;
      if (retire) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: memory responders with a scoreboard of
// expected fetch addresses, stores and request hold lengths, plus ALU vector table.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted, trap;
`ifdef PERF_COUNTERS_EN
  logic [63:0] perf_cycles, perf_instret;
`endif

  multicycle_cpu #(.WORDSIZE(64), .SIZE(512), .RESET_PC(64'h40)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .trap       (trap)
`ifdef PERF_COUNTERS_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_instret (perf_instret)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } store_t;

  typedef struct {
    string       name;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          a;
    int          b;
    logic [63:0] exp;
  } vec_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] BAD    = 32'h0000_007F;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] imem [256];
  logic [63:0] dmem [64];
  int          dmem_delay = 0;
  logic [63:0] exp_fetch [$];
  store_t      exp_store [$];
  int          exp_hold [$];
  int          fetch_cyc [$];
  logic [31:0] prog [$];
  int          cyc = 0;
  int          dmem_req_cycles = 0;
  int          wait_cnt = 0;
  int          hold_cnt = 0;
  logic [63:0] hold_addr, hold_wdata;
  vec_t        vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] ld(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b011, rd, 7'b0000011);
  endfunction

  function automatic logic [31:0] sd(input int rs2, input int rs1, input int imm);
    logic [11:0] s;
    s = imm[11:0];
    return {s[11:5], 5'(rs2), 5'(rs1), 3'b011, s[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), f3, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic int cyc_between(input int a, input int b);
    if (fetch_cyc.size() > b) return fetch_cyc[b] - fetch_cyc[a];
    return -1;
  endfunction

  // Memory responders and scoreboard; sampled on the falling edge.
  initial begin
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        wait_cnt   = 0;
        hold_cnt   = 0;
      end else begin
        imem_ready = imem_req;
        imem_rdata = imem_req ? imem[imem_addr[9:2]] : 32'h0;
        if (imem_req) begin
          fetch_cyc.push_back(cyc);
          if (exp_fetch.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fetch_extra: unexpected fetch at 0x%0h", imem_addr);
          end else begin
            check("fetch_addr", imem_addr, exp_fetch.pop_front());
          end
        end
        dmem_ready = 1'b0;
        if (dmem_req) begin
          dmem_req_cycles++;
          if (hold_cnt == 0) begin
            hold_addr  = dmem_addr;
            hold_wdata = dmem_wdata;
          end
          hold_cnt++;
          dmem_rdata = dmem[dmem_addr[8:3]];
          if (wait_cnt == dmem_delay) begin
            dmem_ready = 1'b1;
            wait_cnt   = 0;
            if (hold_cnt > 1) begin
              check("dmem_addr_stable", dmem_addr, hold_addr);
              check("dmem_wdata_stable", dmem_wdata, hold_wdata);
            end
            if (exp_hold.size() > 0) check("dmem_hold_cycles", 64'(hold_cnt), 64'(exp_hold.pop_front()));
            hold_cnt = 0;
            if (dmem_we) begin
              if (exp_store.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL store_extra: unexpected store to 0x%0h data 0x%0h", dmem_addr, dmem_wdata);
              end else begin
                store_t s;
                s = exp_store.pop_front();
                check("store_addr", dmem_addr, s.addr);
                check("store_data", dmem_wdata, s.data);
              end
              dmem[dmem_addr[8:3]] = dmem_wdata;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic start_test();
    exp_fetch.delete();
    exp_store.delete();
    exp_hold.delete();
    fetch_cyc.delete();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    foreach (prog[i]) imem[16 + i] = prog[i];
    for (int i = 0; i < 64; i++) dmem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    dmem_req_cycles = 0;
    check("reset_imem_req", {63'd0, imem_req}, 64'd0);
    check("reset_imem_addr", imem_addr, 64'd0);
    check("reset_dmem_req", {63'd0, dmem_req}, 64'd0);
    check("reset_halted_trap", {62'd0, halted, trap}, 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic push_fetches(input int n);
    for (int i = 0; i < n; i++) exp_fetch.push_back(64'h40 + 64'(4 * i));
  endtask

  task automatic run_to_stop(input int budget);
    int n;
    n = 0;
    while (!(halted || trap) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(halted || trap)) begin
      checks++;
      failures++;
      $display("FAIL stop_timeout: core neither halted nor trapped within %0d cycles", budget);
    end
  endtask

  task automatic finish_test(input logic exp_halt, input logic exp_trap);
    int busy;
    busy = 0;
    check("halted", {63'd0, halted}, {63'd0, exp_halt});
    check("trap", {63'd0, trap}, {63'd0, exp_trap});
    repeat (4) begin
      @(negedge clk);
      if (imem_req || dmem_req) busy++;
    end
    check("quiet_after_stop", 64'(busy), 64'd0);
    check("fetch_queue_drained", 64'(exp_fetch.size()), 64'd0);
    check("store_queue_drained", 64'(exp_store.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"add",     7'h00, 3'b000,     5,  -3, 64'd2};
    vecs[1] = '{"sub",     7'h20, 3'b000,     5,  -3, 64'd8};
    vecs[2] = '{"and",     7'h00, 3'b111,     6,   3, 64'd2};
    vecs[3] = '{"or",      7'h00, 3'b110,     6,   3, 64'd7};
    vecs[4] = '{"xor",     7'h00, 3'b100,     6,   3, 64'd5};
    vecs[5] = '{"slt_lt",  7'h00, 3'b010,    -3,   5, 64'd1};
    vecs[6] = '{"slt_ge",  7'h00, 3'b010,     5,  -3, 64'd0};
    vecs[7] = '{"add_neg", 7'h00, 3'b000, -2048,  -1, 64'hFFFF_FFFF_FFFF_F7FF};
    vecs[8] = '{"sub_neg", 7'h20, 3'b000,     0,   1, 64'hFFFF_FFFF_FFFF_FFFF};

    // ALU vector table: two ADDIs, the op, store result, EBREAK.
    foreach (vecs[i]) begin
      dmem_delay = 0;
      prog = {addi(1, 0, vecs[i].a), addi(2, 0, vecs[i].b),
              rtype(vecs[i].f7, vecs[i].f3, 3, 1, 2), sd(3, 0, 0), EBREAK};
      start_test();
      push_fetches(5);
      exp_store.push_back('{64'h0, vecs[i].exp});
      run_to_stop(200);
      finish_test(1'b1, 1'b0);
      check({vecs[i].name, "_three_alu_cycles"}, 64'(cyc_between(0, 3)), 64'd12);
      check({vecs[i].name, "_sd_cycles"}, 64'(cyc_between(3, 4)), 64'd4);
    end

    // Store/load round trip with 3 wait states, plus the last legal doubleword.
    dmem_delay = 3;
    prog = {addi(1, 0, 5), addi(2, 0, -3), rtype(7'h00, 3'b000, 3, 1, 2),
            sd(3, 0, 16), ld(4, 0, 16), sd(4, 0, 24), sd(4, 0, 504), EBREAK};
    start_test();
    push_fetches(8);
    exp_store.push_back('{64'd16, 64'd2});
    exp_store.push_back('{64'd24, 64'd2});
    exp_store.push_back('{64'd504, 64'd2});
    repeat (4) exp_hold.push_back(4);
    run_to_stop(400);
    finish_test(1'b1, 1'b0);
    check("sd_wait_cycles", 64'(cyc_between(3, 4)), 64'd7);
    check("ld_wait_cycles", 64'(cyc_between(4, 5)), 64'd8);

    // Taken BEQ, not-taken BNE, JAL with link observed through a store.
    dmem_delay = 0;
    prog = {addi(1, 0, 7), br(3'b000, 1, 1, 8), BAD, br(3'b001, 1, 1, 8),
            jal(5, 8), BAD, sd(5, 0, 32), EBREAK};
    start_test();
    exp_fetch.push_back(64'h40);
    exp_fetch.push_back(64'h44);
    exp_fetch.push_back(64'h4C);
    exp_fetch.push_back(64'h50);
    exp_fetch.push_back(64'h58);
    exp_fetch.push_back(64'h5C);
    exp_store.push_back('{64'd32, 64'h54});
    run_to_stop(200);
    finish_test(1'b1, 1'b0);
    check("beq_cycles", 64'(cyc_between(1, 2)), 64'd3);
    check("jal_cycles", 64'(cyc_between(3, 4)), 64'd3);

    // Load from SIZE: traps without a data request.
    prog = {addi(1, 0, 512), ld(2, 1, 0), EBREAK};
    start_test();
    push_fetches(2);
    run_to_stop(100);
    finish_test(1'b0, 1'b1);
    check("oob_no_dmem_req", 64'(dmem_req_cycles), 64'd0);

    // Misaligned doubleword load traps.
    prog = {ld(2, 0, 4), EBREAK};
    start_test();
    push_fetches(1);
    run_to_stop(100);
    finish_test(1'b0, 1'b1);
    check("misaligned_no_dmem_req", 64'(dmem_req_cycles), 64'd0);

    // Illegal opcode 0x7F traps.
    prog = {BAD, EBREAK};
    start_test();
    push_fetches(1);
    run_to_stop(100);
    finish_test(1'b0, 1'b1);

    // ECALL halts.
    prog = {ECALL, BAD};
    start_test();
    push_fetches(1);
    run_to_stop(100);
    finish_test(1'b1, 1'b0);

    // Reset in the middle of a stalled store: request drops at once, core restarts at RESET_PC.
    dmem_delay = 20;
    prog = {sd(0, 0, 8), EBREAK};
    start_test();
    push_fetches(1);
    begin
      int n;
      n = 0;
      while (!dmem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_mem_req_seen", {63'd0, dmem_req}, 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drops_dmem_req", {63'd0, dmem_req}, 64'd0);
    dmem_delay = 0;
    start_test();
    push_fetches(2);
    exp_store.push_back('{64'd8, 64'd0});
    run_to_stop(100);
    finish_test(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
